// File: rtl/inst_encoder_pkg.sv
// Shared LEGv8 encoding constants, instruction kinds, FSM states and a range helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package legv8_pkg;

    localparam int KIND_W   = 3;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 26;
    localparam int WORD_W   = 32;
    localparam int D_IMM_W  = 9;
    localparam int CB_IMM_W = 19;

    typedef enum logic [KIND_W-1:0] {
        K_LDUR = 3'd0,
        K_STUR = 3'd1,
        K_CBZ  = 3'd2,
        K_ADD  = 3'd3,
        K_SUB  = 3'd4,
        K_AND  = 3'd5,
        K_ORR  = 3'd6,
        K_B    = 3'd7
    } kind_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic {
        ACCEPT = 1'b0,
        FULL   = 1'b1
    } state_t;

    // True when the signed immediate fits in a signed field of the given width:
    // every bit above the field's sign bit must replicate that sign bit.
    function automatic logic imm_fits(input logic [IMM_W-1:0] v, input int width);
        logic signed [IMM_W-1:0] sh;
        sh = $signed(v) >>> (width - 1);
        return (sh == '0) || (sh == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Symbolic-instruction request channel into the encoder.
// Latency: n/a (wires only).
// Backpressure: in_ready from the encoder gates the transfer.
interface inst_encoder_if;

    logic                          in_valid;
    logic                          in_ready;
    logic [legv8_pkg::KIND_W-1:0]  in_kind;
    logic [legv8_pkg::REG_W-1:0]   in_rd;
    logic [legv8_pkg::REG_W-1:0]   in_rn;
    logic [legv8_pkg::REG_W-1:0]   in_rm;
    logic [legv8_pkg::IMM_W-1:0]   in_imm;

    modport master (
        output in_valid, in_kind, in_rd, in_rn, in_rm, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_rn, in_rm, in_imm,
        output in_ready
    );

endinterface

// File: rtl/inst_encoder_pack.sv
// Packs a symbolic LEGv8 instruction into its 32-bit word and flags immediate range.
// Latency: combinational.
// Backpressure: none.
module inst_pack
    import legv8_pkg::*;
(
    input  logic [KIND_W-1:0] kind,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rn,
    input  logic [REG_W-1:0]  rm,
    input  logic [IMM_W-1:0]  imm,
    output logic [WORD_W-1:0] word,
    output logic              range_ok
);

    // Select format by kind; R-format ignores imm, B-format takes any immediate.
    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        case (kind_t'(kind))
            K_LDUR: begin
                word     = {OP_LDUR, imm[8:0], 2'b00, rn, rd};
                range_ok = imm_fits(imm, D_IMM_W);
            end
            K_STUR: begin
                word     = {OP_STUR, imm[8:0], 2'b00, rn, rd};
                range_ok = imm_fits(imm, D_IMM_W);
            end
            K_CBZ: begin
                word     = {OP_CBZ, imm[18:0], rd};
                range_ok = imm_fits(imm, CB_IMM_W);
            end
            K_ADD:   word = {OP_ADD, rm, 6'b000000, rn, rd};
            K_SUB:   word = {OP_SUB, rm, 6'b000000, rn, rd};
            K_AND:   word = {OP_AND, rm, 6'b000000, rn, rd};
            K_ORR:   word = {OP_ORR, rm, 6'b000000, rn, rd};
            K_B:     word = {OP_B, imm};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streams symbolic instructions into instruction memory at a self-incrementing address.
// Latency: one cycle from accepting edge to wr_en/wr_addr/wr_data.
// Backpressure: in_ready drops while full or during clear; out-of-range beats are consumed and dropped.
module inst_encoder
    import legv8_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    inst_encoder_if.slave     req,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              err
);

    localparam logic [AW:0] PTR_LAST = (AW+1)'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [AW:0]       ptr;
    logic [WORD_W-1:0] pk_word;
    logic              pk_ok;
    logic              accept;
    logic              wr_take;

    inst_pack u_pack (
        .kind     (req.in_kind),
        .rd       (req.in_rd),
        .rn       (req.in_rn),
        .rm       (req.in_rm),
        .imm      (req.in_imm),
        .word     (pk_word),
        .range_ok (pk_ok)
    );

    assign accept  = req.in_valid && req.in_ready;
    assign wr_take = accept && pk_ok;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // Go full when the write that lands on the last address is taken; only clear leaves full.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT:  if (wr_take && (ptr == PTR_LAST)) state_nxt = FULL;
            FULL:    if (clear) state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    // Ready only while accepting and not restarting, so clear always wins over in_valid.
    always_comb begin
        req.in_ready = (state == ACCEPT) && !clear;
        full         = (state == FULL);
    end

    // Pointer, sticky error and the registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= wr_take;
            if (wr_take) begin
                wr_addr <= ptr[AW-1:0];
                wr_data <= pk_word;
            end
            if (clear) begin
                ptr <= '0;
                err <= 1'b0;
            end else begin
                if (wr_take) ptr <= ptr + (AW+1)'(1);
                if (accept && !pk_ok) err <= 1'b1;
            end
        end
    end

    assign count = ptr;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed encodings, full/clear, mid-stream reset, random beats.
// Latency: expects writes one cycle after each accepted in-range beat.
// Backpressure: driver waits on in_ready with a bounded cycle budget.
module tb_inst_encoder;

    import legv8_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        int     addr;
        longint data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [AW:0]       count;
    logic              full;
    logic              err;

    inst_encoder_if bus ();

    inst_encoder #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .req     (bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .count   (count),
        .full    (full),
        .err     (err)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    exp_t   sb[$];
    int     m_ptr = 0;
    bit     m_err = 0;
    longint last_addr = 0;
    longint last_data = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference encoder: field values placed by weight, negative immediates folded modulo field size.
    function automatic longint model_word(input int kind, input int rd, input int rn, input int rm,
                                          input int imm, output bit ok);
        longint w;
        longint d9;
        longint c19;
        longint b26;
        d9  = ((longint'(imm) % 512) + 512) % 512;
        c19 = ((longint'(imm) % 524288) + 524288) % 524288;
        b26 = ((longint'(imm) % 67108864) + 67108864) % 67108864;
        ok  = 1;
        w   = 0;
        case (kind)
            0: begin w = 64'h7C2 * 2097152 + d9 * 4096 + rn * 32 + rd; ok = (imm >= -256 && imm <= 255); end
            1: begin w = 64'h7C0 * 2097152 + d9 * 4096 + rn * 32 + rd; ok = (imm >= -256 && imm <= 255); end
            2: begin w = 64'hB4 * 16777216 + c19 * 32 + rd; ok = (imm >= -262144 && imm <= 262143); end
            3: w = 64'h458 * 2097152 + rm * 65536 + rn * 32 + rd;
            4: w = 64'h658 * 2097152 + rm * 65536 + rn * 32 + rd;
            5: w = 64'h450 * 2097152 + rm * 65536 + rn * 32 + rd;
            6: w = 64'h550 * 2097152 + rm * 65536 + rn * 32 + rd;
            default: w = 5 * 67108864 + b26;
        endcase
        return w;
    endfunction

    // Drive one beat (left valid on return), wait for acceptance, update the model, check status.
    task automatic send(input int kind, input int rd, input int rn, input int rm, input int imm,
                        input longint exp_word = -1);
        bit     ok;
        longint w;
        int     waited = 0;
        bus.in_valid = 1'b1;
        bus.in_kind  = 3'(kind);
        bus.in_rd    = 5'(rd);
        bus.in_rn    = 5'(rn);
        bus.in_rm    = 5'(rm);
        bus.in_imm   = 26'(imm);
        w = model_word(kind, rd, rn, rm, imm, ok);
        if (exp_word >= 0) w = exp_word;
        #1;
        check("in_ready", longint'(bus.in_ready), (m_ptr < DEPTH) ? 1 : 0);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (ok) begin
            sb.push_back('{addr: m_ptr, data: w});
            m_ptr++;
        end else begin
            m_err = 1;
        end
        @(negedge clk);
        check("count", longint'(count), m_ptr);
        check("full", longint'(full), (m_ptr == DEPTH) ? 1 : 0);
        check("err", longint'(err), longint'(m_err));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Synchronous restart; in_valid is left as the caller had it so clear must win over it.
    task automatic do_clear();
        clear = 1'b1;
        #1;
        check("ready_in_clear", longint'(bus.in_ready), 0);
        @(posedge clk);
        m_ptr = 0;
        m_err = 0;
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid = 1'b0;
        check("count_clr", longint'(count), 0);
        check("full_clr", longint'(full), 0);
        check("err_clr", longint'(err), 0);
    endtask

    // Monitor: every expected write must appear on the negedge after its accepting edge, else the port holds.
    always @(negedge clk) begin
        if (reset) begin
            last_addr = 0;
            last_data = 0;
        end else if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("wr_en", longint'(wr_en), 1);
            check("wr_addr", longint'(wr_addr), e.addr);
            check("wr_data", longint'(wr_data), e.data);
            last_addr = longint'(wr_addr);
            last_data = longint'(wr_data);
        end else begin
            check("wr_en_idle", longint'(wr_en), 0);
            check("hold_addr", longint'(wr_addr), last_addr);
            check("hold_data", longint'(wr_data), last_data);
            if (wr_en) begin
                last_addr = longint'(wr_addr);
                last_data = longint'(wr_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int bnd[10];
        bnd = '{-256, 255, 256, -257, -262144, 262143, 262144, -262145, 0, -1};

        reset        = 1'b1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_kind  = '0;
        bus.in_rd    = '0;
        bus.in_rn    = '0;
        bus.in_rm    = '0;
        bus.in_imm   = '0;

        repeat (2) @(negedge clk);
        check("rst_wr_en", longint'(wr_en), 0);
        check("rst_wr_addr", longint'(wr_addr), 0);
        check("rst_wr_data", longint'(wr_data), 0);
        check("rst_count", longint'(count), 0);
        check("rst_full", longint'(full), 0);
        check("rst_err", longint'(err), 0);
        reset = 1'b0;
        #1;
        check("rst_ready", longint'(bus.in_ready), 1);
        @(negedge clk);

        // Directed encodings; LDUR/STUR back-to-back.
        send(3, 3, 1, 2, 0, 64'h8B020023);
        idle();
        send(0, 2, 0, 0, -8, 64'hF85F8002);
        send(1, 4, 1, 0, 16, 64'hF8010024);
        idle();

        // Out-of-range D immediate is dropped, err sticks, next ADD fills the last slot.
        send(0, 1, 1, 0, 256);
        send(3, 7, 8, 9, 0);
        check("full_after_4", longint'(full), 1);

        // Fifth beat held while full; clear releases it at address 0, then B back-to-back.
        bus.in_valid = 1'b1;
        bus.in_kind  = 3'd2;
        bus.in_rd    = 5'd5;
        bus.in_rn    = 5'd0;
        bus.in_rm    = 5'd0;
        bus.in_imm   = 26'd3;
        #1;
        check("held_ready", longint'(bus.in_ready), 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("held_ready", longint'(bus.in_ready), 0);
            check("held_err", longint'(err), 1);
        end
        do_clear();
        send(2, 5, 0, 0, 3, 64'hB4000065);
        send(7, 0, 0, 0, -1, 64'h17FFFFFF);
        idle();

        // Reset right after an accepting edge discards the pending write.
        bus.in_valid = 1'b1;
        bus.in_kind  = 3'd3;
        bus.in_rd    = 5'd1;
        bus.in_rn    = 5'd2;
        bus.in_rm    = 5'd3;
        bus.in_imm   = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        bus.in_valid = 1'b0;
        #1;
        check("mid_rst_wr_en", longint'(wr_en), 0);
        check("mid_rst_wr_addr", longint'(wr_addr), 0);
        check("mid_rst_wr_data", longint'(wr_data), 0);
        check("mid_rst_count", longint'(count), 0);
        check("mid_rst_full", longint'(full), 0);
        check("mid_rst_err", longint'(err), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ptr = 0;
        m_err = 0;
        @(negedge clk);
        check("post_rst_ready", longint'(bus.in_ready), 1);

        // Random mix of kinds and immediates around the range boundaries.
        for (int i = 0; i < 400; i++) begin
            int k;
            int imm;
            int r;
            k = int'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            if (m_ptr == DEPTH || $urandom_range(0, 15) == 0) begin
                bus.in_valid = ($urandom_range(0, 1) == 1);
                do_clear();
            end
            if (r == 0)      imm = bnd[$urandom_range(0, 9)];
            else if (r < 4)  imm = int'($urandom_range(0, 600)) - 300;
            else if (r < 6)  imm = int'($urandom_range(0, 1048576)) - 524288;
            else             imm = int'($urandom_range(0, 67108863)) - 33554432;
            send(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), imm);
            if ($urandom_range(0, 3) == 0) idle();
        end

        repeat (3) idle();
        check("sb_drain", longint'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
